// File: rtl/jelly_cache_fill_control_if.sv
// Interface bundling the lookup stream, the forwarded stream, the memory read
// burst channel and the data-RAM write port of jelly_cache_fill_control.
interface jelly_cache_fill_control_if #(
    parameter int USER_BITS        = 1,
    parameter int WAY_WIDTH        = 1,
    parameter int INDEX_WIDTH      = 3,
    parameter int TAG_WIDTH        = 1,
    parameter int LINE_BEATS_WIDTH = 2,
    parameter int DATA_WIDTH       = 32,
    parameter int ADDR_WIDTH       = TAG_WIDTH + INDEX_WIDTH + LINE_BEATS_WIDTH,
    parameter int RAM_ADDR_WIDTH   = WAY_WIDTH + INDEX_WIDTH + LINE_BEATS_WIDTH
);
    logic [USER_BITS-1:0]      s_user;
    logic [INDEX_WIDTH-1:0]    s_index;
    logic [WAY_WIDTH-1:0]      s_way;
    logic [TAG_WIDTH-1:0]      s_tag;
    logic                      s_hit;
    logic                      s_strb;
    logic                      s_valid;
    logic                      s_ready;

    logic [USER_BITS-1:0]      m_user;
    logic [INDEX_WIDTH-1:0]    m_index;
    logic [WAY_WIDTH-1:0]      m_way;
    logic [TAG_WIDTH-1:0]      m_tag;
    logic                      m_hit;
    logic                      m_strb;
    logic                      m_valid;
    logic                      m_ready;

    logic [ADDR_WIDTH-1:0]     mem_araddr;
    logic                      mem_arvalid;
    logic                      mem_arready;
    logic [DATA_WIDTH-1:0]     mem_rdata;
    logic                      mem_rlast;
    logic                      mem_rvalid;
    logic                      mem_rready;

    logic                      ram_we;
    logic [RAM_ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0]     ram_wdata;

    // slave: the fill controller itself
    modport slave (
        input  s_user, s_index, s_way, s_tag, s_hit, s_strb, s_valid,
        output s_ready,
        output m_user, m_index, m_way, m_tag, m_hit, m_strb, m_valid,
        input  m_ready,
        output mem_araddr, mem_arvalid,
        input  mem_arready, mem_rdata, mem_rlast, mem_rvalid,
        output mem_rready,
        output ram_we, ram_addr, ram_wdata
    );

    // master: the environment around it (tag unit, memory, downstream stage)
    modport master (
        output s_user, s_index, s_way, s_tag, s_hit, s_strb, s_valid,
        input  s_ready,
        input  m_user, m_index, m_way, m_tag, m_hit, m_strb, m_valid,
        output m_ready,
        input  mem_araddr, mem_arvalid,
        output mem_arready, mem_rdata, mem_rlast, mem_rvalid,
        input  mem_rready,
        input  ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/jelly_cache_fill_control.sv
// Cache line fill controller: passes hits through, stalls on a strobed miss to
// fetch one line as a fixed-length burst into the data RAM, then forwards it.
module jelly_cache_fill_control #(
    parameter int USER_WIDTH       = 0,
    parameter int WAY_WIDTH        = 1,
    parameter int INDEX_WIDTH      = 3,
    parameter int TAG_WIDTH        = 1,
    parameter int LINE_BEATS_WIDTH = 2,
    parameter int DATA_WIDTH       = 32,
    parameter int ADDR_WIDTH       = TAG_WIDTH + INDEX_WIDTH + LINE_BEATS_WIDTH
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        cke,
    jelly_cache_fill_control_if.slave   bus,
    output logic                        busy,
    output logic                        rlast_err
);
    localparam int USER_BITS      = (USER_WIDTH > 0) ? USER_WIDTH : 1;
    localparam int CNT_W          = (LINE_BEATS_WIDTH > 0) ? LINE_BEATS_WIDTH : 1;
    localparam int RAM_ADDR_WIDTH = WAY_WIDTH + INDEX_WIDTH + LINE_BEATS_WIDTH;
    localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'((1 << LINE_BEATS_WIDTH) - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_FILL, ST_OUT} state_t;

    state_t                    state_q,     state_d;
    logic [USER_BITS-1:0]      user_q,      user_d;
    logic [INDEX_WIDTH-1:0]    index_q,     index_d;
    logic [WAY_WIDTH-1:0]      way_q,       way_d;
    logic [TAG_WIDTH-1:0]      tag_q,       tag_d;
    logic                      hit_q,       hit_d;
    logic                      strb_q,      strb_d;
    logic                      m_valid_q,   m_valid_d;
    logic [ADDR_WIDTH-1:0]     araddr_q,    araddr_d;
    logic                      arvalid_q,   arvalid_d;
    logic                      rready_q,    rready_d;
    logic [CNT_W-1:0]          cnt_q,       cnt_d;
    logic                      ram_we_q,    ram_we_d;
    logic [RAM_ADDR_WIDTH-1:0] ram_addr_q,  ram_addr_d;
    logic [DATA_WIDTH-1:0]     ram_wdata_q, ram_wdata_d;
    logic                      busy_q,      busy_d;
    logic                      rerr_q,      rerr_d;

    logic s_ready;
    logic s_acc, m_acc, ar_acc, r_acc, beat_last;

    always_comb begin
        // gated by reset so the accept line reads 0 while the block is held in reset
        s_ready   = reset_n & ((state_q == ST_IDLE) | ((state_q == ST_OUT) & bus.m_ready));
        s_acc     = cke & bus.s_valid & s_ready;
        m_acc     = cke & m_valid_q & bus.m_ready;
        ar_acc    = cke & arvalid_q & bus.mem_arready;
        r_acc     = cke & rready_q & bus.mem_rvalid;
        beat_last = (cnt_q == BEAT_LAST);

        state_d     = state_q;
        user_d      = user_q;
        index_d     = index_q;
        way_d       = way_q;
        tag_d       = tag_q;
        hit_d       = hit_q;
        strb_d      = strb_q;
        m_valid_d   = m_valid_q;
        araddr_d    = araddr_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        cnt_d       = cnt_q;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        busy_d      = busy_q;
        rerr_d      = rerr_q;

        case (state_q)
            ST_IDLE, ST_OUT: begin
                if (m_acc) begin
                    state_d   = ST_IDLE;
                    m_valid_d = 1'b0;
                end
                if (s_acc) begin
                    user_d  = (USER_WIDTH > 0) ? bus.s_user : '0;
                    index_d = bus.s_index;
                    way_d   = bus.s_way;
                    tag_d   = bus.s_tag;
                    hit_d   = bus.s_hit;
                    strb_d  = bus.s_strb;
                    if (!bus.s_strb || bus.s_hit) begin
                        state_d   = ST_OUT;
                        m_valid_d = 1'b1;
                    end else begin
                        state_d   = ST_ADDR;
                        m_valid_d = 1'b0;
                        araddr_d  = ADDR_WIDTH'({bus.s_tag, bus.s_index}) << LINE_BEATS_WIDTH;
                        arvalid_d = 1'b1;
                        busy_d    = 1'b1;
                    end
                end
            end
            ST_ADDR: begin
                if (ar_acc) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_FILL;
                end
            end
            ST_FILL: begin
                if (r_acc) begin
                    ram_we_d    = 1'b1;
                    ram_addr_d  = (RAM_ADDR_WIDTH'({way_q, index_q}) << LINE_BEATS_WIDTH)
                                | RAM_ADDR_WIDTH'(cnt_q);
                    ram_wdata_d = bus.mem_rdata;
                    // the beat counter ends the burst; rlast is only audited
                    if (bus.mem_rlast != beat_last) begin
                        rerr_d = 1'b1;
                    end
                    if (beat_last) begin
                        cnt_d     = '0;
                        rready_d  = 1'b0;
                        busy_d    = 1'b0;
                        m_valid_d = 1'b1;
                        state_d   = ST_OUT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            user_q      <= '0;
            index_q     <= '0;
            way_q       <= '0;
            tag_q       <= '0;
            hit_q       <= 1'b0;
            strb_q      <= 1'b0;
            m_valid_q   <= 1'b0;
            araddr_q    <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            cnt_q       <= '0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            busy_q      <= 1'b0;
            rerr_q      <= 1'b0;
        end else if (cke) begin
            state_q     <= state_d;
            user_q      <= user_d;
            index_q     <= index_d;
            way_q       <= way_d;
            tag_q       <= tag_d;
            hit_q       <= hit_d;
            strb_q      <= strb_d;
            m_valid_q   <= m_valid_d;
            araddr_q    <= araddr_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            cnt_q       <= cnt_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            busy_q      <= busy_d;
            rerr_q      <= rerr_d;
        end
    end

    assign bus.s_ready     = s_ready;
    assign bus.m_user      = user_q;
    assign bus.m_index     = index_q;
    assign bus.m_way       = way_q;
    assign bus.m_tag       = tag_q;
    assign bus.m_hit       = hit_q;
    assign bus.m_strb      = strb_q;
    assign bus.m_valid     = m_valid_q;
    assign bus.mem_araddr  = araddr_q;
    assign bus.mem_arvalid = arvalid_q;
    assign bus.mem_rready  = rready_q;
    assign bus.ram_we      = ram_we_q;
    assign bus.ram_addr    = ram_addr_q;
    assign bus.ram_wdata   = ram_wdata_q;
    assign busy            = busy_q;
    assign rlast_err       = rerr_q;
endmodule

// File: tb/tb_jelly_cache_fill_control.sv
// Bench for jelly_cache_fill_control: directed and random traffic checked every
// cycle against a transaction-level model, plus hand-computed literal checks.
module tb_jelly_cache_fill_control;
    localparam int UW = 4, WW = 1, IW = 3, TW = 1, LBW = 2, DW = 32;
    localparam int AW = TW + IW + LBW, RAW = WW + IW + LBW, BEATS = 1 << LBW;
    localparam int LIM = 3000;

    logic clk, rst_n, cke, busy, rlast_err;

    jelly_cache_fill_control_if #(.USER_BITS(UW), .WAY_WIDTH(WW), .INDEX_WIDTH(IW),
        .TAG_WIDTH(TW), .LINE_BEATS_WIDTH(LBW), .DATA_WIDTH(DW)) bus ();

    jelly_cache_fill_control #(.USER_WIDTH(UW), .WAY_WIDTH(WW), .INDEX_WIDTH(IW),
        .TAG_WIDTH(TW), .LINE_BEATS_WIDTH(LBW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset_n(rst_n), .cke(cke), .bus(bus), .busy(busy), .rlast_err(rlast_err));

    initial begin clk = 1'b0; forever #5 clk = ~clk; end

    typedef struct { logic [UW-1:0] user; logic [IW-1:0] index; logic [WW-1:0] way;
                     logic [TW-1:0] tag; logic hit; logic strb; } ent_t;
    typedef struct { logic [RAW-1:0] a; logic [DW-1:0] d; } wr_t;

    // model state
    ent_t   q[$];
    wr_t    wq[$], wlog[$];
    logic [AW-1:0] arlog[$];
    bit     hitlog[$];
    longint mhs_cyc[$];
    longint cyc = 0;
    int     pending = 0, arv_seen = 0;
    bit     ar_done = 0, err_m = 0;
    logic [AW-1:0] exp_ar = '0;
    int     checks = 0, errors = 0;

    // environment knobs
    int ar_mode = 0, rlast_bad = -1;
    bit r_gap = 0, rand_cke = 0, rand_mready = 0, junk_r = 0;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] base, input int k);
        return 32'h5A5A0000 ^ {16'(base), 16'(k)};
    endfunction

    function automatic logic [63:0] pack(input ent_t e);
        return 64'({e.user, e.index, e.way, e.tag, e.hit, e.strb});
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({bus.m_valid, bus.s_ready, busy, rlast_err, bus.mem_arvalid, bus.mem_araddr,
                    bus.mem_rready, bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.m_user,
                    bus.m_index, bus.m_way, bus.m_tag, bus.m_hit, bus.m_strb});
    endfunction

    // compare process: check outputs against model, then apply this edge's handshakes
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            q.delete(); wq.delete();
            pending = 0; ar_done = 0; err_m = 0;
        end else begin
            bit mv;
            mv = (q.size() > 0) && (pending == 0);
            chk("busy", 64'(busy), 64'(pending > 0));
            chk("mem_rready", 64'(bus.mem_rready), 64'(pending > 0 && ar_done));
            chk("mem_arvalid", 64'(bus.mem_arvalid), 64'(pending > 0 && !ar_done));
            if (bus.mem_arvalid) chk("mem_araddr", 64'(bus.mem_araddr), 64'(exp_ar));
            chk("m_valid", 64'(bus.m_valid), 64'(mv));
            if (bus.m_valid && q.size() > 0)
                chk("m_payload", 64'({bus.m_user, bus.m_index, bus.m_way, bus.m_tag,
                                      bus.m_hit, bus.m_strb}), pack(q[0]));
            chk("s_ready", 64'(bus.s_ready), 64'(q.size() == 0 || (mv && bus.m_ready)));
            chk("rlast_err", 64'(rlast_err), 64'(err_m));
            chk("ram_we", 64'(bus.ram_we), 64'(wq.size() > 0));
            if (bus.ram_we && cke && wq.size() > 0) begin
                chk("ram_addr", 64'(bus.ram_addr), 64'(wq[0].a));
                chk("ram_wdata", 64'(bus.ram_wdata), 64'(wq[0].d));
                wlog.push_back('{a: bus.ram_addr, d: bus.ram_wdata});
                void'(wq.pop_front());
            end
            if (cke && bus.mem_arvalid) arv_seen++;
            if (cke && bus.mem_arvalid && bus.mem_arready) begin
                ar_done = 1;
                arlog.push_back(bus.mem_araddr);
            end
            if (cke && bus.mem_rvalid && bus.mem_rready && pending > 0 && q.size() > 0) begin
                int k, a;
                k = BEATS - pending;
                if (bus.mem_rlast != (k == BEATS - 1)) err_m = 1;
                a = ((int'(q[0].way) << IW) + int'(q[0].index)) * BEATS + k;
                wq.push_back('{a: RAW'(a), d: bus.mem_rdata});
                pending--;
            end
            if (cke && bus.m_valid && bus.m_ready && q.size() > 0) begin
                chk("fill_writes_done", 64'(wq.size()), 64'(0));
                hitlog.push_back(bus.m_hit);
                mhs_cyc.push_back(cyc);
                void'(q.pop_front());
            end
            if (cke && bus.s_valid && bus.s_ready) begin
                ent_t e;
                e.user = bus.s_user; e.index = bus.s_index; e.way = bus.s_way;
                e.tag = bus.s_tag; e.hit = bus.s_hit; e.strb = bus.s_strb;
                q.push_back(e);
                if (e.strb && !e.hit) begin
                    pending = BEATS;
                    ar_done = 0;
                    exp_ar = AW'(((int'(e.tag) << IW) + int'(e.index)) * BEATS);
                end
            end
        end
    end

    // memory / downstream / clock-enable responder
    initial begin
        int beats_left, mem_k, ar_wait;
        logic [AW-1:0] mem_base;
        beats_left = 0; mem_k = 0; ar_wait = 0; mem_base = '0;
        cke = 1'b1; bus.m_ready = 1'b1; bus.mem_arready = 1'b0;
        bus.mem_rvalid = 1'b0; bus.mem_rdata = '0; bus.mem_rlast = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                beats_left = 0; ar_wait = 0;
            end else begin
                if (cke && bus.mem_arvalid && bus.mem_arready) begin
                    beats_left = BEATS; mem_base = bus.mem_araddr; mem_k = 0; ar_wait = 0;
                end else if (cke && bus.mem_arvalid) begin
                    ar_wait++;
                end
                if (cke && bus.mem_rvalid && bus.mem_rready && beats_left > 0) begin
                    mem_k++; beats_left--;
                end
            end
            @(posedge clk); #1;
            cke = rand_cke ? ($urandom_range(0, 9) < 8) : 1'b1;
            bus.m_ready = rand_mready ? 1'($urandom_range(0, 1)) : 1'b1;
            case (ar_mode)
                1:       bus.mem_arready = (ar_wait >= 10);
                2:       bus.mem_arready = ($urandom_range(0, 3) != 0);
                default: bus.mem_arready = 1'b1;
            endcase
            if (beats_left > 0) begin
                bus.mem_rvalid = r_gap ? ($urandom_range(0, 2) != 0) : 1'b1;
                bus.mem_rdata  = mem_word(mem_base, mem_k);
                bus.mem_rlast  = (mem_k == BEATS - 1) ^ (mem_k == rlast_bad);
            end else begin
                bus.mem_rvalid = junk_r ? ($urandom_range(0, 3) == 0) : 1'b0;
                bus.mem_rdata  = $urandom;
                bus.mem_rlast  = 1'($urandom_range(0, 1));
            end
        end
    end

    // called right after a posedge (+#1); returns at the next posedge (+#1)
    task automatic send(input int u, input int idx, input int w, input int t,
                        input bit h, input bit st);
        int n;
        bit acc;
        bus.s_user = UW'(u); bus.s_index = IW'(idx); bus.s_way = WW'(w);
        bus.s_tag = TW'(t); bus.s_hit = h; bus.s_strb = st; bus.s_valid = 1'b1;
        n = 0; acc = 0;
        while (!acc && n < LIM) begin
            @(negedge clk);
            acc = rst_n && cke && bus.s_ready;
            n++;
        end
        if (!acc) chk("send_accept_timeout", 64'(acc), 64'(1));
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while ((q.size() > 0 || pending > 0) && n < LIM);
        if (q.size() > 0 || pending > 0) chk("idle_timeout", 64'(q.size()), 64'(0));
        @(posedge clk); #1;
    endtask

    task automatic clear_logs();
        wlog.delete(); arlog.delete(); hitlog.delete(); mhs_cyc.delete(); arv_seen = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.s_valid = 1'b0; bus.s_user = '0; bus.s_index = '0; bus.s_way = '0;
        bus.s_tag = '0; bus.s_hit = 1'b0; bus.s_strb = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_outputs_zero", all_outs(), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: hit stream, back to back
        clear_logs();
        for (int i = 0; i < 8; i++) send(i, i, i & 1, (i >> 1) & 1, 1'b1, 1'b1);
        wait_idle();
        chk("t1_outputs", 64'(mhs_cyc.size()), 64'(8));
        if (mhs_cyc.size() == 8) chk("t1_back_to_back", 64'(mhs_cyc[7] - mhs_cyc[0]), 64'(7));
        chk("t1_no_burst", 64'(arlog.size()), 64'(0));

        // 2: miss tag=1 index=5 way=1
        clear_logs();
        send(3, 5, 1, 1, 1'b0, 1'b1);
        wait_idle();
        chk("t2_ar_count", 64'(arlog.size()), 64'(1));
        if (arlog.size() > 0) chk("t2_araddr", 64'(arlog[0]), 64'h34);
        chk("t2_writes", 64'(wlog.size()), 64'(4));
        if (wlog.size() == 4) begin
            chk("t2_w0_addr", 64'(wlog[0].a), 64'h34);
            chk("t2_w0_data", 64'(wlog[0].d), 64'h5A6E0000);
            chk("t2_w3_addr", 64'(wlog[3].a), 64'h37);
            chk("t2_w3_data", 64'(wlog[3].d), 64'h5A6E0003);
        end
        if (hitlog.size() > 0) chk("t2_m_hit", 64'(hitlog[0]), 64'(0));

        // 3: slow address accept and gappy data
        clear_logs();
        ar_mode = 1; r_gap = 1;
        send(9, 2, 0, 0, 1'b0, 1'b1);
        wait_idle();
        chk("t3_arvalid_cycles", 64'(arv_seen), 64'(11));
        chk("t3_writes", 64'(wlog.size()), 64'(4));
        ar_mode = 0; r_gap = 0;

        // 4: early rlast on the second beat
        clear_logs();
        chk("t4_err_before", 64'(rlast_err), 64'(0));
        rlast_bad = 1;
        send(1, 6, 0, 1, 1'b0, 1'b1);
        wait_idle();
        rlast_bad = -1;
        chk("t4_rlast_err", 64'(rlast_err), 64'(1));
        chk("t4_writes", 64'(wlog.size()), 64'(4));

        // 5: random traffic with cke, backpressure and stray beats
        clear_logs();
        rand_cke = 1; rand_mready = 1; ar_mode = 2; r_gap = 1; junk_r = 1;
        for (int i = 0; i < 2000; i++)
            send($urandom, $urandom, $urandom, $urandom,
                 $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 9);
        wait_idle();
        chk("t5_outputs", 64'(mhs_cyc.size()), 64'(2000));
        rand_cke = 0; rand_mready = 0; ar_mode = 0; junk_r = 0;

        // 6: reset in the middle of a fill
        clear_logs();
        send(2, 3, 1, 0, 1'b0, 1'b1);
        begin
            int n;
            n = 0;
            while (wlog.size() < 2 && n < LIM) begin @(negedge clk); #1; n++; end
            chk("t6_reach_fill", 64'(wlog.size() >= 2), 64'(1));
        end
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("t6_reset_outputs_zero", all_outs(), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        r_gap = 0;
        clear_logs();
        repeat (4) @(posedge clk);
        #1;
        chk("t6_no_write_after_reset", 64'(wlog.size()), 64'(0));
        send(5, 7, 0, 1, 1'b0, 1'b1);
        wait_idle();
        chk("t6_next_ar", 64'(arlog.size()), 64'(1));
        if (arlog.size() > 0) chk("t6_next_araddr", 64'(arlog[0]), 64'h3C);
        chk("t6_next_writes", 64'(wlog.size()), 64'(4));
        chk("t6_next_out", 64'(mhs_cyc.size()), 64'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
